// File: rtl/psum_out_seq_ctrl_pkg.sv
// Shared types for the psum output sequencer, its counters and the packer.
// Holds the default widths, the state encoding and the layer operation codes.
package psum_out_seq_ctrl_pkg;

  localparam int SEQ_CH_W  = 9;
  localparam int SEQ_PIX_W = 16;
  localparam int SEQ_CNT_W = SEQ_CH_W + SEQ_PIX_W;

  typedef enum logic [1:0] {
    OP_CONV   = 2'd0,
    OP_DWCONV = 2'd1,
    OP_POOL   = 2'd2,
    OP_FC     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_FINISH = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/psum_out_seq_ctrl_if.sv
// Bundles the sequencer's layer config, PE-side intake and packer-side outputs.
// master is the sequencer's view; slave is the view of whatever surrounds it.
interface psum_out_seq_ctrl_if
  import psum_out_seq_ctrl_pkg::*;
#(
  parameter int CH_W  = SEQ_CH_W,
  parameter int PIX_W = SEQ_PIX_W,
  parameter int CNT_W = SEQ_CNT_W
);

  logic             cfg_start;
  logic [1:0]       cfg_operation;
  logic [CH_W-1:0]  cfg_out_ch;
  logic [PIX_W-1:0] cfg_out_pix;
  logic             abort;
  logic             fifo_afull;
  logic             src_valid;
  logic             src_data;
  logic             src_ready;
  logic             pk_in_valid;
  logic             pk_in_data;
  logic             pk_layer_finish;
  logic [1:0]       pk_operation;
  logic [CH_W-1:0]  pk_out_ch_size;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bits_sent;

  modport master (
    input  cfg_start, cfg_operation, cfg_out_ch, cfg_out_pix,
    input  abort, fifo_afull, src_valid, src_data,
    output src_ready, pk_in_valid, pk_in_data, pk_layer_finish,
    output pk_operation, pk_out_ch_size, busy, done, bits_sent
  );

  modport slave (
    output cfg_start, cfg_operation, cfg_out_ch, cfg_out_pix,
    output abort, fifo_afull, src_valid, src_data,
    input  src_ready, pk_in_valid, pk_in_data, pk_layer_finish,
    input  pk_operation, pk_out_ch_size, busy, done, bits_sent
  );

endinterface

// File: rtl/psum_out_seq_ctrl_counter.sv
// Nested channel/pixel counter: ch wraps at ch_max_i, pix steps on each ch wrap.
// last_o flags the beat that closes the layer; both counters return to 0 on it.
module psum_ch_pix_counter
  import psum_out_seq_ctrl_pkg::*;
#(
  parameter int CH_W  = SEQ_CH_W,
  parameter int PIX_W = SEQ_PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [CH_W-1:0]  ch_max_i,
  input  logic [PIX_W-1:0] pix_max_i,
  output logic             last_o
);

  logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             ch_wrap;

  assign ch_wrap = (ch_cnt_q == ch_max_i);
  assign last_o  = ch_wrap && (pix_cnt_q == pix_max_i);

  always_comb begin
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    if (clear_i) begin
      ch_cnt_d  = '0;
      pix_cnt_d = '0;
    end else if (step_i) begin
      if (ch_wrap) begin
        ch_cnt_d  = '0;
        pix_cnt_d = last_o ? '0 : pix_cnt_q + PIX_W'(1);
      end else begin
        ch_cnt_d  = ch_cnt_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
    end else begin
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

endmodule

// File: rtl/psum_out_seq_ctrl.sv
// Layer sequencer between the PE array psum output and the psum packer.
// Forwards accepted psum bits one cycle late, then emits layer_finish and done.
module psum_out_seq_ctrl
  import psum_out_seq_ctrl_pkg::*;
#(
  parameter int CH_W  = SEQ_CH_W,
  parameter int PIX_W = SEQ_PIX_W,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  psum_out_seq_ctrl_if.master bus
);

  seq_state_e       state_q, state_d;
  op_e              op_q, op_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic             pk_valid_q, pk_valid_d;
  logic             pk_data_q, pk_data_d;

  logic             start_ok;
  logic             empty_cfg;
  logic             src_ready;
  logic             handshake;
  logic             last_beat;

  assign start_ok  = (state_q == ST_IDLE) && bus.cfg_start;
  assign empty_cfg = (bus.cfg_out_ch == '0) || (bus.cfg_out_pix == '0);
  assign src_ready = (state_q == ST_RUN) && !bus.fifo_afull;
  assign handshake = src_ready && bus.src_valid;

  psum_ch_pix_counter #(
    .CH_W  (CH_W),
    .PIX_W (PIX_W)
  ) u_ch_pix_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (start_ok),
    .step_i    (handshake),
    .ch_max_i  (out_ch_q - CH_W'(1)),
    .pix_max_i (out_pix_q - PIX_W'(1)),
    .last_o    (last_beat)
  );

  // An abort that coincides with a handshake still routes through FLUSH so the
  // forwarded bit never lands in the same cycle as layer_finish.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_start) state_d = empty_cfg ? ST_FINISH : ST_RUN;
      end
      ST_RUN: begin
        if (handshake && last_beat) state_d = ST_FLUSH;
        else if (bus.abort)         state_d = handshake ? ST_FLUSH : ST_FINISH;
      end
      ST_FLUSH:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    out_ch_d   = out_ch_q;
    out_pix_d  = out_pix_q;
    bits_d     = bits_q;
    pk_valid_d = handshake;
    pk_data_d  = handshake && bus.src_data;
    if (start_ok) begin
      op_d      = op_e'(bus.cfg_operation);
      out_ch_d  = bus.cfg_out_ch;
      out_pix_d = bus.cfg_out_pix;
      bits_d    = '0;
    end else if (handshake && (bits_q != '1)) begin
      bits_d    = bits_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CONV;
      out_ch_q   <= '0;
      out_pix_q  <= '0;
      bits_q     <= '0;
      pk_valid_q <= 1'b0;
      pk_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      out_ch_q   <= out_ch_d;
      out_pix_q  <= out_pix_d;
      bits_q     <= bits_d;
      pk_valid_q <= pk_valid_d;
      pk_data_q  <= pk_data_d;
    end
  end

  assign bus.src_ready       = src_ready;
  assign bus.pk_in_valid     = pk_valid_q;
  assign bus.pk_in_data      = pk_data_q;
  assign bus.pk_layer_finish = (state_q == ST_FINISH);
  assign bus.pk_operation    = op_q;
  assign bus.pk_out_ch_size  = out_ch_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = (state_q == ST_DONE);
  assign bus.bits_sent       = bits_q;

endmodule
